// File: rtl/fifo_rd_stream.sv
// Burst reader that drains a FIFO into a 2-entry valid/ready output buffer.
// Define FIFO_RD_STREAM_STAT_EN to add the saturating 16-bit accepted-word counter word_cnt.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_aempty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  flush,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy
`ifdef FIFO_RD_STREAM_STAT_EN
    ,
    output logic [15:0]           word_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    localparam logic [7:0] LastRead = 8'(BURST_LEN - 1);

    state_t                r_state;
    state_t                w_stateNext;
    logic [7:0]            r_burstCnt;
    logic [7:0]            w_burstCntNext;
    logic                  r_inflight;
    logic [1:0]            r_occ;
    logic                  r_wrPtr;
    logic                  r_rdPtr;
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic                  w_pop;
    logic                  w_push;
    logic                  w_credit;
    logic [2:0]            w_pending;

    // Credit counts words that will still occupy the buffer once this cycle's pop is taken.
    assign w_pop     = out_valid & out_ready;
    assign w_push    = r_inflight;
    assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_credit  = (w_pending <= 3'd1);

    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_buf[r_rdPtr];
    assign busy      = (r_state == READ) | r_inflight | (r_occ != 2'd0);

    always_comb begin
        w_stateNext    = r_state;
        w_burstCntNext = r_burstCnt;
        fifo_rd_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!fifo_empty && (!fifo_aempty || flush)) begin
                    w_stateNext    = READ;
                    w_burstCntNext = 8'd0;
                end
            end
            READ: begin
                fifo_rd_en = !fifo_empty && w_credit;
                if (fifo_empty) begin
                    w_stateNext = IDLE;
                end else if (fifo_rd_en) begin
                    w_burstCntNext = r_burstCnt + 8'd1;
                    if (r_burstCnt == LastRead) begin
                        w_stateNext = IDLE;
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            r_state    <= IDLE;
            r_burstCnt <= 8'd0;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_wrPtr    <= 1'b0;
            r_rdPtr    <= 1'b0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_burstCnt <= w_burstCntNext;
            r_inflight <= fifo_rd_en;
            if (w_push) begin
                r_buf[r_wrPtr] <= fifo_rd_data;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

`ifdef FIFO_RD_STREAM_STAT_EN
    logic [15:0] r_wordCnt;

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            r_wordCnt <= 16'd0;
        end else if (w_pop && (r_wordCnt != 16'hFFFF)) begin
            r_wordCnt <= r_wordCnt + 16'd1;
        end
    end

    assign word_cnt = r_wordCnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: queue-based FIFO and stream reference model.
// Define FIFO_RD_STREAM_STAT_EN to also exercise word_cnt.
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int BL = 4;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n;
    logic          fifo_empty;
    logic          fifo_aempty;
    logic [DW-1:0] fifo_rd_data;
    logic          flush;
    logic          fifo_rd_en;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
`ifdef FIFO_RD_STREAM_STAT_EN
    logic [15:0]   word_cnt;
`endif

    fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_aempty  (fifo_aempty),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .fifo_rd_en   (fifo_rd_en),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .busy         (busy)
`ifdef FIFO_RD_STREAM_STAT_EN
        ,
        .word_cnt     (word_cnt)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    int            testsRun  = 0;
    int            failCount = 0;
    logic [DW-1:0] fifoQ[$];
    logic [DW-1:0] sbQ[$];
    bit            inBurst   = 0;
    int            burstReads = 0;
    bit            inflightM = 0;
    int            aeThresh  = 2;
    logic [DW-1:0] pendData  = '0;
    bit            pendValid = 0;
    int            acceptCnt = 0;
    bit            expRdEn, expValid, expBusy;
    logic [DW-1:0] expData;
    bit            smpRdEn, smpPop;

    // Drive this cycle's inputs, derive expectations from the model, then wait for the sample point.
    task automatic drive(input bit rst, input bit rdy, input bit fl);
        int occ;
        bit pop;
        rd_rst_n     = ~rst;
        out_ready    = rdy;
        flush        = fl;
        fifo_empty   = (fifoQ.size() == 0);
        fifo_aempty  = (fifoQ.size() <= aeThresh);
        fifo_rd_data = pendValid ? pendData : DW'($urandom);
        occ      = sbQ.size() - int'(inflightM);
        expValid = (occ != 0);
        expData  = expValid ? sbQ[0] : '0;
        pop      = expValid && rdy;
        expRdEn  = inBurst && !fifo_empty && ((sbQ.size() - int'(pop)) <= 1);
        expBusy  = inBurst || inflightM || (occ != 0);
        @(negedge rd_clk);
        smpRdEn = (fifo_rd_en === 1'b1);
        smpPop  = (out_valid === 1'b1) && rdy;
    endtask

    // Advance one clock and update the FIFO environment and the reference model.
    task automatic tick();
        @(posedge rd_clk);
        pendValid = 0;
        if (smpRdEn && fifoQ.size() > 0) begin
            pendData  = fifoQ.pop_front();
            pendValid = 1;
        end
        if (!rd_rst_n) begin
            inBurst    = 0;
            burstReads = 0;
            inflightM  = 0;
            acceptCnt  = 0;
            sbQ.delete();
        end else begin
            if (smpPop && sbQ.size() > 0) begin
                void'(sbQ.pop_front());
                acceptCnt++;
            end
            if (pendValid) sbQ.push_back(pendData);
            inflightM = smpRdEn;
            if (!inBurst) begin
                if (!fifo_empty && (!fifo_aempty || flush)) begin
                    inBurst    = 1;
                    burstReads = 0;
                end
            end else if (fifo_empty) begin
                inBurst = 0;
            end else if (expRdEn) begin
                burstReads++;
                if (burstReads == BL) inBurst = 0;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        fifoQ.delete();
        drive(1, 0, 0); tick();
        drive(1, 0, 0); tick();
    endtask

    task automatic test_reset();
        apply_reset();
        drive(0, 0, 0);
        testsRun++; if (fifo_rd_en !== 1'b0) begin failCount++; $display("[TB] FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
        testsRun++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        testsRun++; if (out_data !== '0) begin failCount++; $display("[TB] FAIL reset_out_data got=%h exp=0", out_data); end
        testsRun++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        tick();
    endtask

    task automatic test_basic_burst();
        int            expRd[6] = '{1, 2, 3, 4, 6, 7};
        int            rdCyc[$];
        int            vldCyc[$];
        logic [DW-1:0] words[$];
        logic [DW-1:0] got[$];
        apply_reset();
        aeThresh = 1;
        for (int i = 0; i < 6; i++) words.push_back(DW'($urandom));
        fifoQ = words;
        for (int c = 0; c < 14; c++) begin
            drive(0, 1, 0);
            testsRun++; if (fifo_rd_en !== expRdEn) begin failCount++; $display("[TB] FAIL basic_rd_en cyc=%0d got=%b exp=%b", c, fifo_rd_en, expRdEn); end
            if (fifo_rd_en === 1'b1) rdCyc.push_back(c);
            if (out_valid === 1'b1) begin
                got.push_back(out_data);
                vldCyc.push_back(c);
            end
            tick();
        end
        testsRun++;
        if (rdCyc.size() != 6) begin
            failCount++; $display("[TB] FAIL basic_read_count got=%0d exp=6", rdCyc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                testsRun++; if (rdCyc[i] != expRd[i]) begin failCount++; $display("[TB] FAIL basic_read_cycle idx=%0d got=%0d exp=%0d", i, rdCyc[i], expRd[i]); end
            end
        end
        testsRun++;
        if (got.size() != 6) begin
            failCount++; $display("[TB] FAIL basic_word_count got=%0d exp=6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                testsRun++; if (got[i] !== words[i]) begin failCount++; $display("[TB] FAIL basic_data idx=%0d got=%h exp=%h", i, got[i], words[i]); end
                testsRun++; if (vldCyc[i] != expRd[i] + 2) begin failCount++; $display("[TB] FAIL basic_latency idx=%0d got=%0d exp=%0d", i, vldCyc[i], expRd[i] + 2); end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] words[$];
        logic [DW-1:0] got[$];
        logic [DW-1:0] held;
        bit            seen = 0;
        int            reads = 0;
        apply_reset();
        aeThresh = 1;
        for (int i = 0; i < 6; i++) words.push_back(DW'($urandom));
        fifoQ = words;
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, 0);
            testsRun++; if (fifo_rd_en !== expRdEn) begin failCount++; $display("[TB] FAIL bp_rd_en cyc=%0d got=%b exp=%b", c, fifo_rd_en, expRdEn); end
            if (fifo_rd_en === 1'b1) reads++;
            if (out_valid === 1'b1) begin
                if (!seen) begin
                    held = out_data;
                    seen = 1;
                end else begin
                    testsRun++; if (out_data !== held) begin failCount++; $display("[TB] FAIL bp_stable cyc=%0d got=%h exp=%h", c, out_data, held); end
                end
            end
            tick();
        end
        testsRun++; if (reads != 2) begin failCount++; $display("[TB] FAIL bp_reads got=%0d exp=2", reads); end
        testsRun++; if (held !== words[0]) begin failCount++; $display("[TB] FAIL bp_head got=%h exp=%h", held, words[0]); end
        for (int c = 0; c < 30; c++) begin
            drive(0, 1, 0);
            testsRun++; if (fifo_rd_en !== expRdEn) begin failCount++; $display("[TB] FAIL bp_rel_rd_en cyc=%0d got=%b exp=%b", c, fifo_rd_en, expRdEn); end
            if (out_valid === 1'b1) got.push_back(out_data);
            tick();
        end
        testsRun++;
        if (got.size() != 6) begin
            failCount++; $display("[TB] FAIL bp_word_count got=%0d exp=6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                testsRun++; if (got[i] !== words[i]) begin failCount++; $display("[TB] FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], words[i]); end
            end
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] w;
        logic [DW-1:0] got[$];
        int            reads = 0;
        apply_reset();
        aeThresh = 2;
        w = DW'($urandom);
        fifoQ.push_back(w);
        for (int c = 0; c < 5; c++) begin
            drive(0, 1, 0);
            testsRun++; if (fifo_rd_en !== 1'b0) begin failCount++; $display("[TB] FAIL flush_idle_rd_en cyc=%0d got=%b exp=0", c, fifo_rd_en); end
            tick();
        end
        drive(0, 1, 1);
        tick();
        for (int c = 0; c < 8; c++) begin
            drive(0, 1, 0);
            testsRun++; if (fifo_rd_en !== expRdEn) begin failCount++; $display("[TB] FAIL flush_rd_en cyc=%0d got=%b exp=%b", c, fifo_rd_en, expRdEn); end
            if (fifo_rd_en === 1'b1) reads++;
            if (out_valid === 1'b1) got.push_back(out_data);
            tick();
        end
        testsRun++; if (reads != 1) begin failCount++; $display("[TB] FAIL flush_reads got=%0d exp=1", reads); end
        testsRun++; if (got.size() != 1 || got[0] !== w) begin failCount++; $display("[TB] FAIL flush_word got_count=%0d exp=1 word=%h", got.size(), w); end
        drive(0, 1, 0);
        testsRun++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL flush_busy_end got=%b exp=0", busy); end
        tick();
    endtask

    task automatic test_empty_mid_burst();
        logic [DW-1:0] words[$];
        logic [DW-1:0] got[$];
        int            reads = 0;
        apply_reset();
        aeThresh = 0;
        for (int i = 0; i < 2; i++) words.push_back(DW'($urandom));
        fifoQ = words;
        for (int c = 0; c < 10; c++) begin
            drive(0, 1, 0);
            testsRun++; if (fifo_rd_en !== expRdEn) begin failCount++; $display("[TB] FAIL emid_rd_en cyc=%0d got=%b exp=%b", c, fifo_rd_en, expRdEn); end
            if (fifo_empty && fifo_rd_en !== 1'b0) begin failCount++; $display("[TB] FAIL emid_read_on_empty cyc=%0d got=%b exp=0", c, fifo_rd_en); end
            if (fifo_rd_en === 1'b1) reads++;
            if (out_valid === 1'b1) got.push_back(out_data);
            tick();
        end
        testsRun++; if (reads != 2) begin failCount++; $display("[TB] FAIL emid_reads got=%0d exp=2", reads); end
        testsRun++; if (got.size() != 2 || got[0] !== words[0] || got[1] !== words[1]) begin failCount++; $display("[TB] FAIL emid_words got_count=%0d exp=2", got.size()); end
        drive(0, 1, 0);
        testsRun++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL emid_busy_end got=%b exp=0", busy); end
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        aeThresh = 1;
        for (int i = 0; i < 6; i++) fifoQ.push_back(DW'($urandom));
        for (int c = 0; c < 3; c++) begin drive(0, 0, 0); tick(); end
        drive(1, 0, 0); tick();
        drive(0, 0, 0);
        testsRun++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL rmid_out_valid got=%b exp=0", out_valid); end
        testsRun++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL rmid_busy got=%b exp=0", busy); end
        testsRun++; if (fifo_rd_en !== 1'b0) begin failCount++; $display("[TB] FAIL rmid_rd_en got=%b exp=0", fifo_rd_en); end
        tick();
        drive(1, 1, 0);
        testsRun++; if (fifo_rd_en !== 1'b1) begin failCount++; $display("[TB] FAIL rmid_read_in_reset got=%b exp=1", fifo_rd_en); end
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(0, 1, 0);
            testsRun++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL rmid_dropped cyc=%0d got=%b exp=0", c, out_valid); end
            tick();
        end
        for (int c = 0; c < 12; c++) begin
            drive(0, 1, 0);
            testsRun++; if (out_valid !== expValid || (expValid && out_data !== expData)) begin failCount++; $display("[TB] FAIL rmid_stream cyc=%0d got=%b/%h exp=%b/%h", c, out_valid, out_data, expValid, expData); end
            tick();
        end
    endtask

    task automatic test_random();
        apply_reset();
        aeThresh = 2;
        for (int c = 0; c < 1500; c++) begin
            if (fifoQ.size() < 16 && $urandom_range(0, 2) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) fifoQ.push_back(DW'($urandom));
            end
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            testsRun++; if (fifo_rd_en !== expRdEn) begin failCount++; $display("[TB] FAIL rand_rd_en cyc=%0d got=%b exp=%b", c, fifo_rd_en, expRdEn); end
            testsRun++; if (out_valid !== expValid) begin failCount++; $display("[TB] FAIL rand_out_valid cyc=%0d got=%b exp=%b", c, out_valid, expValid); end
            testsRun++; if (busy !== expBusy) begin failCount++; $display("[TB] FAIL rand_busy cyc=%0d got=%b exp=%b", c, busy, expBusy); end
            if (expValid) begin
                testsRun++; if (out_data !== expData) begin failCount++; $display("[TB] FAIL rand_out_data cyc=%0d got=%h exp=%h", c, out_data, expData); end
            end
            testsRun++; if (sbQ.size() > 2) begin failCount++; $display("[TB] FAIL rand_overflow cyc=%0d got=%0d exp<=2", c, sbQ.size()); end
            tick();
        end
    endtask

`ifdef FIFO_RD_STREAM_STAT_EN
    task automatic test_stats();
        int c = 0;
        apply_reset();
        aeThresh = 2;
        while (acceptCnt < 70000 && c < 95000) begin
            while (fifoQ.size() < 8) fifoQ.push_back(DW'($urandom));
            drive(0, 1, 0);
            if (c == 0 || c == 1000) begin
                testsRun++; if (word_cnt !== 16'(acceptCnt)) begin failCount++; $display("[TB] FAIL stat_count cyc=%0d got=%0d exp=%0d", c, word_cnt, acceptCnt); end
            end
            tick();
            c++;
        end
        testsRun++; if (acceptCnt < 70000) begin failCount++; $display("[TB] FAIL stat_timeout got=%0d exp=70000", acceptCnt); end
        drive(0, 0, 0);
        testsRun++; if (word_cnt !== 16'hFFFF) begin failCount++; $display("[TB] FAIL stat_saturate got=%h exp=ffff", word_cnt); end
        tick();
        drive(1, 0, 0); tick();
        drive(0, 0, 0);
        testsRun++; if (word_cnt !== 16'd0) begin failCount++; $display("[TB] FAIL stat_reset got=%h exp=0", word_cnt); end
        tick();
    endtask
`endif

    initial begin
        rd_rst_n     = 1'b0;
        fifo_empty   = 1'b1;
        fifo_aempty  = 1'b1;
        fifo_rd_data = '0;
        flush        = 1'b0;
        out_ready    = 1'b0;
        #1;
        test_reset();
        test_basic_burst();
        test_back_pressure();
        test_flush();
        test_empty_mid_burst();
        test_reset_mid();
        test_random();
`ifdef FIFO_RD_STREAM_STAT_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
